mem_read_fsm: RTL and testbench

//  Read-side companion to the ToF memory writer. On a start pulse it walks the ToF sample

---
 rtl/mem_read_fsm_if.sv | 26 ++
 rtl/mem_read_fsm.sv | 138 +++++++++++++
 tb/tb_mem_read_fsm.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_fsm_if.sv
// BRAM port-B read port and outbound sample stream of the ToF memory reader.
// The master side is the reader; the slave side is the BRAM plus the stream consumer.
interface mem_read_fsm_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic              enb;
    logic [IDX_W-1:0]  addrb;
    logic [DATA_W-1:0] doutb;

    logic [DATA_W-1:0] m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output enb, addrb, m_data, m_index, m_last, m_valid,
        input  doutb, m_ready
    );

    modport slave (
        input  enb, addrb, m_data, m_index, m_last, m_valid,
        output doutb, m_ready
    );
endinterface

// File: rtl/mem_read_fsm.sv
// Walks the ToF sample BRAM once per start pulse, reads every enabled slot and
// streams each sample out with its slot index and an end-of-pass flag.
module mem_read_fsm #(
    parameter int N_SLOTS = 8,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 3,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_SLOTS-1:0] rd_mask,
    output logic               busy,
    output logic               done,
    mem_read_fsm_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(N_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t             state;
    logic [N_SLOTS-1:0] mask;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   wait_cnt;

    logic               enb_q;
    logic [IDX_W-1:0]   addrb_q;
    logic [DATA_W-1:0]  m_data_q;
    logic [IDX_W-1:0]   m_index_q;
    logic               m_last_q;
    logic               m_valid_q;

    // Enabled slots strictly above the current pointer; empty means this beat ends the pass.
    logic [N_SLOTS-1:0] upper_bits;
    assign upper_bits = (mask >> ptr) >> 1;

    assign bus.enb     = enb_q;
    assign bus.addrb   = addrb_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_index = m_index_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_valid = m_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            mask      <= '0;
            ptr       <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            enb_q     <= 1'b0;
            addrb_q   <= '0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask  <= rd_mask;
                        ptr   <= '0;
                        busy  <= 1'b1;
                        state <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (mask[ptr]) begin
                        enb_q   <= 1'b1;
                        addrb_q <= ptr;
                        state   <= S_ISSUE;
                    end else if (ptr == LAST_PTR) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end

                S_ISSUE: begin
                    enb_q    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                // Read data is valid on the RD_LAT-th edge after the enable was sampled.
                S_WAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        m_data_q  <= bus.doutb;
                        m_index_q <= ptr;
                        m_last_q  <= (upper_bits == '0);
                        m_valid_q <= 1'b1;
                        state     <= S_PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_PRESENT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        if (m_last_q) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_SCAN;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_fsm.sv
// Self-checking bench for mem_read_fsm: a table of readout passes checked through a
// beat scoreboard, plus hand sequences for restart-while-busy and mid-pass reset.
module tb_mem_read_fsm;

    localparam int N_SLOTS = 8;
    localparam int DATA_W  = 16;
    localparam int IDX_W   = 3;
    localparam int RD_LAT  = 2;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        logic [N_SLOTS-1:0] mask;
        logic [DATA_W-1:0]  base;
        int                 beats;
        int                 done_cyc;
        int                 stall_beat;
        int                 stall_len;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [N_SLOTS-1:0] rd_mask;
    logic               busy;
    logic               done;
    logic               m_ready_r;
    logic [DATA_W-1:0]  stage1;
    logic [DATA_W-1:0]  stage2;
    logic [DATA_W-1:0]  mem [N_SLOTS];

    int vec_count  = 0;
    int miscompares = 0;
    int enb_count  = 0;
    int done_count = 0;
    int beat_num   = 0;
    int stall_at   = -1;
    int stall_len  = 0;
    int stall_left = 0;

    logic               hold_valid;
    logic [DATA_W-1:0]  hold_data;
    logic [IDX_W-1:0]   hold_index;
    logic               hold_last;
    logic [N_SLOTS-1:0] exp_mask;
    beat_t              exp_q[$];
    vec_t               vecs[7];

    always #5 clk = ~clk;

    mem_read_fsm_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    assign bus.doutb   = stage2;
    assign bus.m_ready = m_ready_r;

    mem_read_fsm #(
        .N_SLOTS(N_SLOTS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rd_mask(rd_mask),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    // Two-stage BRAM read pipeline matching RD_LAT = 2.
    always @(posedge clk) begin
        if (bus.enb) stage1 <= mem[bus.addrb];
        stage2 <= stage1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic load_expect(input logic [N_SLOTS-1:0] mask, input logic [DATA_W-1:0] base);
        int hi;
        beat_t b;
        hi = -1;
        for (int i = 0; i < N_SLOTS; i++) begin
            mem[i] = base + DATA_W'(i);
            if (mask[i]) hi = i;
        end
        exp_mask = mask;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (mask[i]) begin
                b.idx  = IDX_W'(i);
                b.data = base + DATA_W'(i);
                b.last = (i == hi);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic apply_stimulus(input logic [N_SLOTS-1:0] mask);
        @(negedge clk);
        start   = 1'b1;
        rd_mask = mask;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 400);
        if (!done) begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected a done pulse", cyc);
        end
    endtask

    // Scoreboard pop, enable/address checks and m_ready back-pressure generation.
    task automatic monitor();
        beat_t b;
        forever begin
            @(negedge clk);
            if (done) done_count++;
            if (bus.enb) begin
                enb_count++;
                check_output("enb_addr_in_mask", 32'(exp_mask[bus.addrb]), 32'd1);
            end
            if (bus.m_valid && m_ready_r) begin
                if (exp_q.size() == 0) begin
                    vec_count++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_beat: got index %0d data %0h, expected no beat",
                             bus.m_index, bus.m_data);
                end else begin
                    b = exp_q.pop_front();
                    check_output("beat_index", 32'(bus.m_index), 32'(b.idx));
                    check_output("beat_data", 32'(bus.m_data), 32'(b.data));
                    check_output("beat_last", 32'(bus.m_last), 32'(b.last));
                end
                beat_num++;
                hold_valid = 1'b0;
                if (beat_num == stall_at) begin
                    m_ready_r  = 1'b0;
                    stall_left = stall_len;
                end
            end else if (bus.m_valid) begin
                check_output("stall_no_enb", 32'(bus.enb), 32'd0);
                if (hold_valid) begin
                    check_output("stall_data_stable", 32'(bus.m_data), 32'(hold_data));
                    check_output("stall_index_stable", 32'(bus.m_index), 32'(hold_index));
                    check_output("stall_last_stable", 32'(bus.m_last), 32'(hold_last));
                end else begin
                    hold_data  = bus.m_data;
                    hold_index = bus.m_index;
                    hold_last  = bus.m_last;
                    hold_valid = 1'b1;
                end
                stall_left--;
                if (stall_left <= 0) m_ready_r = 1'b1;
            end
        end
    endtask

    task automatic run_pass(input vec_t v);
        int cyc;
        int enb0;
        int done0;
        load_expect(v.mask, v.base);
        enb0      = enb_count;
        done0     = done_count;
        stall_at  = (v.stall_beat >= 0) ? beat_num + v.stall_beat : -1;
        stall_len = v.stall_len;
        apply_stimulus(v.mask);
        wait_done(cyc);
        check_output("done_latency", 32'(cyc), 32'(v.done_cyc));
        @(negedge clk);
        check_output("done_one_cycle", 32'(done), 32'd0);
        check_output("busy_after_done", 32'(busy), 32'd0);
        check_output("enb_pulses", 32'(enb_count - enb0), 32'(v.beats));
        check_output("done_pulses", 32'(done_count - done0), 32'd1);
        check_output("beats_left", 32'(exp_q.size()), 32'd0);
        stall_at = -1;
    endtask

    initial begin
        int cyc;
        int enb0;
        int done0;
        int tries;

        vecs[0] = '{8'hFF,        16'hA000, 8, 41, -1, 0};
        vecs[1] = '{8'b1000_0101, 16'h3000, 3, 21, -1, 0};
        vecs[2] = '{8'h00,        16'h0000, 0,  9, -1, 0};
        vecs[3] = '{8'hFF,        16'h4000, 8, 46,  3, 5};
        vecs[4] = '{8'h01,        16'h5000, 1,  6, -1, 0};
        vecs[5] = '{8'h80,        16'h6000, 1, 13, -1, 0};
        vecs[6] = '{8'h5A,        16'h7000, 4, 24, -1, 0};

        reset      = 1'b0;
        start      = 1'b0;
        rd_mask    = '0;
        m_ready_r  = 1'b1;
        hold_valid = 1'b0;
        exp_mask   = '0;
        stage1     = '0;
        stage2     = '0;
        for (int i = 0; i < N_SLOTS; i++) mem[i] = '0;

        fork
            monitor();
        join_none

        #3;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_enb", 32'(bus.enb), 32'd0);
        check_output("reset_m_valid", 32'(bus.m_valid), 32'd0);
        check_output("reset_m_data", 32'(bus.m_data), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] table passes");
        for (int k = 0; k < 7; k++) run_pass(vecs[k]);

        $display("[TB] restart while busy, mask changed mid-pass, start in DONE cycle");
        load_expect(8'b1000_0101, 16'h3100);
        enb0  = enb_count;
        done0 = done_count;
        apply_stimulus(8'b1000_0101);
        rd_mask = 8'hFF;
        repeat (3) @(negedge clk);
        check_output("busy_mid_pass", 32'(busy), 32'd1);
        start   = 1'b1;
        rd_mask = 8'hFF;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rd_mask = 8'h00;
        wait_done(cyc);
        start   = 1'b1;
        rd_mask = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_output("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
        check_output("restart_done_pulses", 32'(done_count - done0), 32'd1);
        check_output("restart_enb_pulses", 32'(enb_count - enb0), 32'd3);
        check_output("restart_beats_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset during WAIT of slot 4");
        load_expect(8'hFF, 16'h8000);
        apply_stimulus(8'hFF);
        tries = 0;
        do begin
            @(negedge clk);
            tries++;
        end while (!(bus.enb && bus.addrb == 3'd4) && tries < 200);
        check_output("slot4_issue_seen", 32'(bus.enb && bus.addrb == 3'd4), 32'd1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_enb", 32'(bus.enb), 32'd0);
        check_output("abort_addrb", 32'(bus.addrb), 32'd0);
        check_output("abort_m_valid", 32'(bus.m_valid), 32'd0);
        check_output("abort_m_last", 32'(bus.m_last), 32'd0);
        check_output("abort_m_index", 32'(bus.m_index), 32'd0);
        check_output("abort_m_data", 32'(bus.m_data), 32'd0);
        check_output("abort_beats_pending", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        done0 = done_count;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check_output("abort_no_done", 32'(done_count - done0), 32'd0);
        check_output("abort_idle_busy", 32'(busy), 32'd0);
        run_pass(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
